// File: rtl/hamster_abi_pkg.sv
// rtl/hamster_abi_pkg.sv - shared types, successor tables and helpers for the ABI encoder decoder
package hamster_abi_pkg;

    typedef logic [1:0] quad_state_t;  // {A, B}

    typedef enum logic [1:0] {
        QUAD_NONE    = 2'd0,
        QUAD_FWD     = 2'd1,
        QUAD_REV     = 2'd2,
        QUAD_ILLEGAL = 2'd3
    } quad_event_t;

    localparam int K_NSTEPS = 6;

    // Successor tables packed as four 2-bit entries indexed by the current state.
    // Forward: 00->10->11->01->00, reverse: 00->01->11->10->00.
    localparam logic [7:0] K_FWD_SUCC = {2'b01, 2'b11, 2'b00, 2'b10};
    localparam logic [7:0] K_REV_SUCC = {2'b10, 2'b00, 2'b11, 2'b01};

    function automatic quad_state_t quad_fwd_succ(input quad_state_t s);
        return K_FWD_SUCC[{s, 1'b0} +: 2];
    endfunction

    function automatic quad_state_t quad_rev_succ(input quad_state_t s);
        return K_REV_SUCC[{s, 1'b0} +: 2];
    endfunction

    function automatic quad_event_t quad_classify(input quad_state_t prev, input quad_state_t cur);
        if (cur == prev) begin
            return QUAD_NONE;
        end
        if (cur == quad_fwd_succ(prev)) begin
            return QUAD_FWD;
        end
        if (cur == quad_rev_succ(prev)) begin
            return QUAD_REV;
        end
        return QUAD_ILLEGAL;
    endfunction

endpackage

// File: rtl/abi_input_filter.sv
// rtl/abi_input_filter.sv - 2-FF synchronizer followed by a hold-length deglitch filter
module abi_input_filter #(
    parameter int K_FILTER_LEN = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_level
);

    localparam int CW = (K_FILTER_LEN > 1) ? $clog2(K_FILTER_LEN) : 1;

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // A new level is accepted only after K_FILTER_LEN consecutive differing samples.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            cnt     <= '0;
            o_level <= 1'b0;
        end else begin
            sync1 <= i_raw;
            sync2 <= sync1;
            if (sync2 != o_level) begin
                if (cnt == CW'(K_FILTER_LEN - 1)) begin
                    o_level <= sync2;
                    cnt     <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/abi_encoder_decoder.sv
// rtl/abi_encoder_decoder.sv - conditions raw ABI encoder inputs and decodes step, index and position events
module abi_encoder_decoder
    import hamster_abi_pkg::*;
#(
    parameter int K_FILTER_LEN = 4,
    parameter int K_POS_WIDTH  = 16,
    parameter int K_NSUBSTEPS  = 10
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_enc_a,
    input  logic                          i_enc_b,
    input  logic                          i_enc_i,
    input  logic                          i_enable,
    input  logic                          i_index_en,
    input  logic                          i_index_zero,
    input  logic [2:0]                    i_index_step,
    input  logic                          i_pos_clear,
    input  logic                          i_err_clear,
    output logic                          o_step_trigger,
    output logic                          o_dir_rev,
    output logic                          o_force_step_trigger,
    output logic [2:0]                    o_force_step_value,
    output logic [$clog2(K_NSUBSTEPS)-1:0] o_force_substep,
    output logic [K_POS_WIDTH-1:0]        o_position,
    output logic [K_POS_WIDTH-1:0]        o_index_pos,
    output logic                          o_err
);

    logic        filt_a;
    logic        filt_b;
    logic        filt_i;
    quad_state_t cur_state;
    quad_state_t prev_state;
    logic        prev_i;
    quad_event_t quad_ev;
    logic        step_valid;
    logic        index_hit;

    abi_input_filter #(.K_FILTER_LEN(K_FILTER_LEN)) u_filt_a (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_raw   (i_enc_a),
        .o_level (filt_a)
    );

    abi_input_filter #(.K_FILTER_LEN(K_FILTER_LEN)) u_filt_b (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_raw   (i_enc_b),
        .o_level (filt_b)
    );

    abi_input_filter #(.K_FILTER_LEN(K_FILTER_LEN)) u_filt_i (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_raw   (i_enc_i),
        .o_level (filt_i)
    );

    assign cur_state       = {filt_a, filt_b};
    assign quad_ev         = quad_classify(prev_state, cur_state);
    assign step_valid      = i_enable && ((quad_ev == QUAD_FWD) || (quad_ev == QUAD_REV));
    assign index_hit       = i_enable && i_index_en && filt_i && !prev_i;
    assign o_force_substep = '0;

    // Previous-state registers track even while disabled so re-enable never sees a stale transition.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            prev_state           <= '0;
            prev_i               <= 1'b0;
            o_step_trigger       <= 1'b0;
            o_dir_rev            <= 1'b0;
            o_force_step_trigger <= 1'b0;
            o_force_step_value   <= '0;
            o_position           <= '0;
            o_index_pos          <= '0;
            o_err                <= 1'b0;
        end else begin
            prev_state           <= cur_state;
            prev_i               <= filt_i;
            o_step_trigger       <= step_valid;
            o_force_step_trigger <= index_hit;

            if (step_valid) begin
                o_dir_rev <= (quad_ev == QUAD_REV);
            end

            if (index_hit) begin
                o_force_step_value <= (i_index_step < 3'(K_NSTEPS)) ? i_index_step : 3'd0;
                o_index_pos        <= o_position;
            end

            // Counter priority: explicit clear, then index zeroing, then step; wraps in two's complement.
            if (i_pos_clear) begin
                o_position <= '0;
            end else if (index_hit && i_index_zero) begin
                o_position <= '0;
            end else if (step_valid && (quad_ev == QUAD_FWD)) begin
                o_position <= o_position + K_POS_WIDTH'(1);
            end else if (step_valid) begin
                o_position <= o_position - K_POS_WIDTH'(1);
            end

            if (i_err_clear) begin
                o_err <= 1'b0;
            end
            if (i_enable && (quad_ev == QUAD_ILLEGAL)) begin
                o_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_abi_encoder_decoder.sv
// tb/tb_abi_encoder_decoder.sv - directed self-checking bench for abi_encoder_decoder
module tb_abi_encoder_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        enc_a, enc_b, enc_i;
    logic        enable, index_en, index_zero;
    logic [2:0]  index_step;
    logic        pos_clear, err_clear;
    logic        step_trigger, dir_rev, force_trigger, err;
    logic [2:0]  force_value;
    logic [3:0]  force_substep;
    logic [15:0] position, index_pos;

    logic        f_a, f_b;
    logic        f_step_trigger, f_dir_rev, f_force_trigger, f_err;
    logic [2:0]  f_force_value;
    logic [3:0]  f_force_substep;
    logic [15:0] f_position, f_index_pos;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    abi_encoder_decoder dut (
        .i_clk(clk), .i_rst(rst), .i_enc_a(enc_a), .i_enc_b(enc_b), .i_enc_i(enc_i),
        .i_enable(enable), .i_index_en(index_en), .i_index_zero(index_zero),
        .i_index_step(index_step), .i_pos_clear(pos_clear), .i_err_clear(err_clear),
        .o_step_trigger(step_trigger), .o_dir_rev(dir_rev),
        .o_force_step_trigger(force_trigger), .o_force_step_value(force_value),
        .o_force_substep(force_substep), .o_position(position), .o_index_pos(index_pos),
        .o_err(err)
    );

    // Single-sample filter instance so the long positive wrap fits in a short run.
    abi_encoder_decoder #(.K_FILTER_LEN(1)) dut_fast (
        .i_clk(clk), .i_rst(rst), .i_enc_a(f_a), .i_enc_b(f_b), .i_enc_i(1'b0),
        .i_enable(1'b1), .i_index_en(1'b0), .i_index_zero(1'b0),
        .i_index_step(3'd0), .i_pos_clear(1'b0), .i_err_clear(1'b0),
        .o_step_trigger(f_step_trigger), .o_dir_rev(f_dir_rev),
        .o_force_step_trigger(f_force_trigger), .o_force_step_value(f_force_value),
        .o_force_substep(f_force_substep), .o_position(f_position), .o_index_pos(f_index_pos),
        .o_err(f_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs n cycles, counting pulses and recording the edge count after the sampling edge.
    task automatic hold(input int n, output int sp, output int sl, output int fp, output int fl);
        sp = 0; sl = 0; fp = 0; fl = 0;
        for (int k = 1; k <= n; k++) begin
            tick();
            if (step_trigger === 1'b1) begin
                sp++;
                if (sl == 0) sl = k - 1;
            end
            if (force_trigger === 1'b1) begin
                fp++;
                if (fl == 0) fl = k - 1;
            end
        end
    endtask

    task automatic pulse_pos_clear();
        pos_clear = 1'b1; tick(); pos_clear = 1'b0;
    endtask

    task automatic pulse_err_clear();
        err_clear = 1'b1; tick(); err_clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        vectors++;
        if ({step_trigger, dir_rev, force_trigger, force_value, force_substep, err} !== 11'd0) begin
            miscompares++;
            $display("FAIL reset_flags got=%b want=0", {step_trigger, dir_rev, force_trigger, force_value, force_substep, err});
        end
        vectors++;
        if ({position, index_pos} !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_pos got=%h want=0", {position, index_pos});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_forward();
        logic [1:0] seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
        int sp, sl, fp, fl;
        for (int s = 0; s < 4; s++) begin
            {enc_a, enc_b} = seq[s];
            hold(8, sp, sl, fp, fl);
            vectors++;
            if (sp !== 1 || sl !== 6 || dir_rev !== 1'b0 || position !== 16'(s + 1)) begin
                miscompares++;
                $display("FAIL fwd_step%0d pulses=%0d lat=%0d dir=%b pos=%h want 1/6/0/%h", s, sp, sl, dir_rev, position, 16'(s + 1));
            end
        end
    endtask

    task automatic test_reverse();
        logic [1:0]  seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
        logic [15:0] exp_pos;
        int sp, sl, fp, fl;
        pulse_pos_clear();
        vectors++;
        if (position !== 16'h0000) begin
            miscompares++;
            $display("FAIL pos_clear got=%h want=0000", position);
        end
        for (int s = 0; s < 4; s++) begin
            {enc_a, enc_b} = seq[s];
            hold(8, sp, sl, fp, fl);
            exp_pos = 16'h0000 - 16'(s + 1);
            vectors++;
            if (sp !== 1 || sl !== 6 || dir_rev !== 1'b1 || position !== exp_pos) begin
                miscompares++;
                $display("FAIL rev_step%0d pulses=%0d lat=%0d dir=%b pos=%h want 1/6/1/%h", s, sp, sl, dir_rev, position, exp_pos);
            end
        end
    endtask

    task automatic test_wrap();
        logic [1:0] seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
        for (int n = 0; n < 32767; n++) begin
            {f_a, f_b} = seq[n % 4];
            tick();
        end
        repeat (5) tick();
        vectors++;
        if (f_position !== 16'h7FFF) begin
            miscompares++;
            $display("FAIL wrap_max got=%h want=7fff", f_position);
        end
        {f_a, f_b} = seq[32767 % 4];
        repeat (5) tick();
        vectors++;
        if (f_position !== 16'h8000 || f_dir_rev !== 1'b0 || f_err !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_pos got=%h dir=%b err=%b want=8000/0/0", f_position, f_dir_rev, f_err);
        end
    endtask

    task automatic test_glitch();
        int sp, sl, fp, fl;
        enc_a = 1'b1;
        repeat (3) tick();
        enc_a = 1'b0;
        hold(12, sp, sl, fp, fl);
        vectors++;
        if (sp !== 0 || position !== 16'hFFFC || err !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch pulses=%0d pos=%h err=%b want 0/fffc/0", sp, position, err);
        end
        enc_a = 1'b1;
        hold(8, sp, sl, fp, fl);
        vectors++;
        if (sp !== 1 || dir_rev !== 1'b0 || position !== 16'hFFFD) begin
            miscompares++;
            $display("FAIL post_glitch_fwd pulses=%0d dir=%b pos=%h want 1/0/fffd", sp, dir_rev, position);
        end
        enc_a = 1'b0;
        hold(8, sp, sl, fp, fl);
        vectors++;
        if (sp !== 1 || dir_rev !== 1'b1 || position !== 16'hFFFC) begin
            miscompares++;
            $display("FAIL post_glitch_rev pulses=%0d dir=%b pos=%h want 1/1/fffc", sp, dir_rev, position);
        end
    endtask

    task automatic test_illegal();
        int sp, sl, fp, fl;
        {enc_a, enc_b} = 2'b11;
        hold(8, sp, sl, fp, fl);
        vectors++;
        if (sp !== 0 || err !== 1'b1 || position !== 16'hFFFC || dir_rev !== 1'b1) begin
            miscompares++;
            $display("FAIL illegal pulses=%0d err=%b pos=%h dir=%b want 0/1/fffc/1", sp, err, position, dir_rev);
        end
        pulse_err_clear();
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_clear got=%b want=0", err);
        end
        {enc_a, enc_b} = 2'b00;
        repeat (6) tick();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        vectors++;
        if (err !== 1'b1 || step_trigger !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_vs_clear err=%b trig=%b want 1/0", err, step_trigger);
        end
        repeat (2) tick();
        vectors++;
        if (position !== 16'hFFFC || err !== 1'b1) begin
            miscompares++;
            $display("FAIL illegal_hold pos=%h err=%b want fffc/1", position, err);
        end
    endtask

    task automatic test_index();
        logic [1:0] seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
        int sp, sl, fp, fl;
        pulse_pos_clear();
        pulse_err_clear();
        for (int s = 0; s < 25; s++) begin
            {enc_a, enc_b} = seq[s % 4];
            hold(8, sp, sl, fp, fl);
        end
        vectors++;
        if (position !== 16'd25) begin
            miscompares++;
            $display("FAIL index_setup pos=%h want=0019", position);
        end
        index_en = 1'b1; index_step = 3'd3; index_zero = 1'b1;
        enc_i = 1'b1;
        hold(8, sp, sl, fp, fl);
        vectors++;
        if (fp !== 1 || fl !== 6 || force_value !== 3'd3 || force_substep !== 4'd0 ||
            index_pos !== 16'd25 || position !== 16'd0) begin
            miscompares++;
            $display("FAIL index_zero pulses=%0d lat=%0d val=%0d sub=%0d ipos=%h pos=%h want 1/6/3/0/0019/0000",
                     fp, fl, force_value, force_substep, index_pos, position);
        end
        enc_i = 1'b0;
        hold(8, sp, sl, fp, fl);
        vectors++;
        if (fp !== 0) begin
            miscompares++;
            $display("FAIL index_fall pulses=%0d want=0", fp);
        end
        index_step = 3'd7;
        enc_i = 1'b1;
        hold(8, sp, sl, fp, fl);
        vectors++;
        if (fp !== 1 || force_value !== 3'd0 || index_pos !== 16'd0) begin
            miscompares++;
            $display("FAIL index_step7 pulses=%0d val=%0d ipos=%h want 1/0/0000", fp, force_value, index_pos);
        end
        enc_i = 1'b0;
        hold(8, sp, sl, fp, fl);
        index_en = 1'b0;
        enc_i = 1'b1;
        hold(8, sp, sl, fp, fl);
        vectors++;
        if (fp !== 0) begin
            miscompares++;
            $display("FAIL index_disabled pulses=%0d want=0", fp);
        end
        enc_i = 1'b0; index_zero = 1'b0;
        hold(8, sp, sl, fp, fl);
    endtask

    task automatic test_disable();
        int sp, sl, fp, fl;
        int total;
        total = 0;
        enable = 1'b0;
        {enc_a, enc_b} = 2'b11;
        hold(8, sp, sl, fp, fl);
        total += sp;
        {enc_a, enc_b} = 2'b01;
        hold(8, sp, sl, fp, fl);
        total += sp;
        vectors++;
        if (total !== 0 || position !== 16'd0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL disabled pulses=%0d pos=%h err=%b want 0/0000/0", total, position, err);
        end
        enable = 1'b1;
        hold(8, sp, sl, fp, fl);
        vectors++;
        if (sp !== 0) begin
            miscompares++;
            $display("FAIL reenable pulses=%0d want=0", sp);
        end
        {enc_a, enc_b} = 2'b00;
        hold(8, sp, sl, fp, fl);
        vectors++;
        if (sp !== 1 || dir_rev !== 1'b0 || position !== 16'd1) begin
            miscompares++;
            $display("FAIL after_reenable pulses=%0d dir=%b pos=%h want 1/0/0001", sp, dir_rev, position);
        end
    endtask

    task automatic test_reset_mid();
        int sp, sl, fp, fl;
        {enc_a, enc_b} = 2'b10;
        repeat (7) tick();
        vectors++;
        if (step_trigger !== 1'b1 || position !== 16'd2) begin
            miscompares++;
            $display("FAIL mid_pulse trig=%b pos=%h want 1/0002", step_trigger, position);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if ({step_trigger, dir_rev, force_trigger, force_value, force_substep, err, position, index_pos} !== 43'd0) begin
            miscompares++;
            $display("FAIL mid_reset got=%h want=0",
                     {step_trigger, dir_rev, force_trigger, force_value, force_substep, err, position, index_pos});
        end
        hold(12, sp, sl, fp, fl);
        vectors++;
        if (sp !== 1 || dir_rev !== 1'b0 || position !== 16'd1) begin
            miscompares++;
            $display("FAIL resume pulses=%0d dir=%b pos=%h want 1/0/0001", sp, dir_rev, position);
        end
        {enc_a, enc_b} = 2'b11;
        hold(8, sp, sl, fp, fl);
        vectors++;
        if (sp !== 1 || sl !== 6 || position !== 16'd2) begin
            miscompares++;
            $display("FAIL resume_step pulses=%0d lat=%0d pos=%h want 1/6/0002", sp, sl, position);
        end
    endtask

    initial begin
        rst = 1'b1;
        enc_a = 1'b0; enc_b = 1'b0; enc_i = 1'b0;
        f_a = 1'b0; f_b = 1'b0;
        enable = 1'b1; index_en = 1'b0; index_zero = 1'b0; index_step = 3'd0;
        pos_clear = 1'b0; err_clear = 1'b0;
        test_reset();
        test_forward();
        test_reverse();
        test_wrap();
        test_glitch();
        test_illegal();
        test_index();
        test_disable();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
